// File: rtl/soc_bus_fabric.sv
// PicoRV32 native-bus interconnect: address decode, fixed or slave-driven ready,
// timeout and unmapped-address error responses with sticky error capture.
module soc_bus_fabric #(
    parameter int unsigned                   NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*8-1:0]       SLAVE_ID       = {8'h07, 8'h06, 8'h05, 8'h04,
                                                               8'h03, 8'h02, 8'h01, 8'h00},
    parameter logic [NUM_SLAVES*4-1:0]       SLAVE_WAIT     = {NUM_SLAVES{4'd1}},
    parameter int unsigned                   TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                   ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                      clk_cpu,
    input  logic                      n_reset,
    input  logic                      mem_valid,
    input  logic [31:0]               mem_addr,
    input  logic [3:0]                mem_wstrb,
    output logic                      mem_ready,
    output logic [31:0]               mem_rdata,
    output logic [NUM_SLAVES-1:0]     s_sel,
    output logic [4*NUM_SLAVES-1:0]   s_wstrb,
    input  logic [32*NUM_SLAVES-1:0]  s_rdata,
    input  logic [NUM_SLAVES-1:0]     s_ready,
    input  logic                      err_clear,
    output logic                      bus_err,
    output logic [31:0]               bus_err_addr
);

    localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned TMax = (TIMEOUT_CYCLES > 15) ? TIMEOUT_CYCLES : 15;
    localparam int unsigned CntW = $clog2(TMax) + 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW-1:0]   idx_q;
    logic              unmapped_q;
    logic              bus_err_q;
    logic [31:0]       bus_err_addr_q;

    logic [7:0]        id_tab    [NUM_SLAVES];
    logic [3:0]        wait_tab  [NUM_SLAVES];
    logic [31:0]       rdata_tab [NUM_SLAVES];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_tab
        assign id_tab[g]    = SLAVE_ID[8*g +: 8];
        assign wait_tab[g]  = SLAVE_WAIT[4*g +: 4];
        assign rdata_tab[g] = s_rdata[32*g +: 32];
    end

    logic              req;
    logic              dec_hit;
    logic [IdxW-1:0]   dec_idx;
    logic [IdxW-1:0]   cur_idx;
    logic [3:0]        cur_wait;
    logic [CntW-1:0]   wait_ext;
    logic              ready;
    logic              err_rsp;
    logic              sel_en;
    logic              err_event;
    logic [NUM_SLAVES-1:0] sel_vec;

    // Requests are masked while in reset so no output can be driven then.
    assign req = mem_valid & n_reset;

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (mem_addr[31:24] == id_tab[i]) begin
                dec_hit = 1'b1;
                dec_idx = IdxW'(i);
            end
        end
    end

    assign cur_idx  = (state_q == StIdle) ? dec_idx : idx_q;
    assign cur_wait = wait_tab[cur_idx];
    assign wait_ext = {{(CntW-4){1'b0}}, cur_wait};

    always_comb begin
        ready   = 1'b0;
        err_rsp = 1'b0;
        sel_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req && dec_hit) begin
                    sel_en = 1'b1;
                    ready  = (cur_wait == 4'd0) && s_ready[cur_idx];
                end
            end
            StWait: begin
                if (req) begin
                    if (unmapped_q) begin
                        ready   = 1'b1;
                        err_rsp = 1'b1;
                    end else if (cur_wait == 4'd0) begin
                        if (s_ready[cur_idx]) begin
                            ready  = 1'b1;
                            sel_en = 1'b1;
                        end else if (cnt_q >= TimeoutCnt) begin
                            ready   = 1'b1;
                            err_rsp = 1'b1;
                        end else begin
                            sel_en = 1'b1;
                        end
                    end else begin
                        sel_en = 1'b1;
                        ready  = (cnt_q >= wait_ext);
                    end
                end
            end
            default: ;
        endcase
    end

    assign err_event = ready & err_rsp;

    always_comb begin
        sel_vec = '0;
        s_wstrb = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            sel_vec[i]       = sel_en && (cur_idx == IdxW'(i));
            s_wstrb[4*i +: 4] = sel_vec[i] ? mem_wstrb : 4'h0;
        end
    end

    assign s_sel        = sel_vec;
    assign mem_ready    = ready;
    assign mem_rdata    = !ready ? 32'h0 : (err_rsp ? ERR_RDATA : rdata_tab[cur_idx]);
    assign bus_err      = bus_err_q;
    assign bus_err_addr = bus_err_addr_q;

    always_ff @(posedge clk_cpu or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            idx_q          <= '0;
            unmapped_q     <= 1'b0;
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= 32'h0;
        end else begin
            // A new error outranks a simultaneous clear and recaptures its address.
            if (err_event) begin
                bus_err_q <= 1'b1;
                if (!bus_err_q || err_clear) begin
                    bus_err_addr_q <= mem_addr;
                end
            end else if (err_clear) begin
                bus_err_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (req) begin
                        idx_q      <= dec_idx;
                        unmapped_q <= !dec_hit;
                        cnt_q      <= CntW'(1);
                        state_q    <= ready ? StResp : StWait;
                    end
                end
                StWait: begin
                    if (!req) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (ready) begin
                        state_q <= StResp;
                        cnt_q   <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
